// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports (P = processor, D = secondary
// requester), the shared dmem port and the arbiter status outputs.
//   slave  : arbiter side (takes requests, drives acks, rdata and mem_*).
//   master : requester / memory side (the opposite directions).
interface dmem_arbiter_if;
  // Port P (processor load/store stage)
  logic        p_req;
  logic [0:31] p_addr;
  logic [0:31] p_wdata;
  logic        p_we;
  logic [0:1]  p_size;
  logic        p_ext;
  logic [0:31] p_rdata;
  logic        p_ack;
  // Port D (preloader / debug DMA)
  logic        d_req;
  logic [0:31] d_addr;
  logic [0:31] d_wdata;
  logic        d_we;
  logic [0:1]  d_size;
  logic        d_ext;
  logic [0:31] d_rdata;
  logic        d_ack;
  // Shared dmem port
  logic [0:31] mem_addr;
  logic [0:31] mem_wdata;
  logic        mem_we;
  logic [0:1]  mem_size;
  logic        mem_ext;
  logic [0:31] mem_rdata;
  // Status
  logic        busy;
  logic        grant;

  modport slave (
    input  p_req, p_addr, p_wdata, p_we, p_size, p_ext,
    input  d_req, d_addr, d_wdata, d_we, d_size, d_ext,
    input  mem_rdata,
    output p_rdata, p_ack, d_rdata, d_ack,
    output mem_addr, mem_wdata, mem_we, mem_size, mem_ext,
    output busy, grant
  );

  modport master (
    output p_req, p_addr, p_wdata, p_we, p_size, p_ext,
    output d_req, d_addr, d_wdata, d_we, d_size, d_ext,
    output mem_rdata,
    input  p_rdata, p_ack, d_rdata, d_ack,
    input  mem_addr, mem_wdata, mem_we, mem_size, mem_ext,
    input  busy, grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one dmem port between the processor (P) and a secondary
// requester (D). Each access runs IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP,
// with round-robin selection when both ports request in the same IDLE cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arbiter_if.slave -- request fields and rdata/ack per port,
//                the dmem port (mem_*), busy and grant status.
// All outputs are registered.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             grant_q;
  logic             busy_q;
  logic             we_q;
  logic [0:31]      mem_addr_q;
  logic [0:31]      mem_wdata_q;
  logic             mem_we_q;
  logic [0:1]       mem_size_q;
  logic             mem_ext_q;
  logic [0:31]      p_rdata_q;
  logic [0:31]      d_rdata_q;
  logic             p_ack_q;
  logic             d_ack_q;

  // Winner and its request fields for an IDLE-cycle grant.
  logic        win_d;
  logic [0:31] addr_d;
  logic [0:31] wdata_d;
  logic        we_d;
  logic [0:1]  size_d;
  logic        ext_d;

  always_comb begin
    win_d = bus.d_req;
    // Contention: the port that did not own the last access wins.
    if (bus.p_req && bus.d_req) win_d = ~last_q;
    addr_d  = win_d ? bus.d_addr  : bus.p_addr;
    wdata_d = win_d ? bus.d_wdata : bus.p_wdata;
    we_d    = win_d ? bus.d_we    : bus.p_we;
    size_d  = win_d ? bus.d_size  : bus.p_size;
    ext_d   = win_d ? bus.d_ext   : bus.p_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_ext_q   <= 1'b0;
      p_rdata_q   <= '0;
      d_rdata_q   <= '0;
      p_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      p_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.p_req || bus.d_req) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            grant_q     <= win_d;
            last_q      <= win_d;
            cnt_q       <= LAT_M1;
            we_q        <= we_d;
            // The mem_* registers double as the request latch.
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_size_q  <= size_d;
            mem_ext_q   <= ext_d;
            // With a single ACCESS cycle, that cycle is already the counter==0 one.
            mem_we_q    <= (MEM_LATENCY == 1) ? we_d : 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q    <= cnt_q - ONE;
            // Write enable only in the final (counter==0) ACCESS cycle.
            mem_we_q <= (cnt_q == ONE) ? we_q : 1'b0;
          end else begin
            state_q     <= RESP;
            if (!we_q) begin
              if (grant_q) d_rdata_q <= bus.mem_rdata;
              else         p_rdata_q <= bus.mem_rdata;
            end
            p_ack_q     <= ~grant_q;
            d_ack_q     <= grant_q;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_ext_q   <= 1'b0;
          end
        end
        RESP: begin
          // Requests are ignored here; a held req is re-sampled in the next IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_ext   = mem_ext_q;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.p_ack     = p_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;

endmodule
